// File: rtl/sort_array_loader.sv
// Streams array elements into consecutive data-memory doublewords while holding the core in reset.
// It then releases the core and counts run cycles until the core halts or the cycle limit expires.
module sort_array_loader #(
    parameter int          N_ELEM     = 8,
    parameter logic [63:0] BASE_ADDR  = 64'd0,
    parameter logic [31:0] MAX_CYCLES = 32'd10000,
    localparam int         CW         = $clog2(N_ELEM + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [63:0]   in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          mem_we,
    output logic [63:0]   mem_addr,
    output logic [63:0]   mem_wdata,
    output logic          cpu_reset,
    input  logic          cpu_halt,
    input  logic          restart,
    output logic [CW-1:0] elem_count,
    output logic [31:0]   cycle_count,
    output logic          load_done,
    output logic          timeout
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state, state_next;
    logic          we_next;
    logic [63:0]   addr_next;
    logic [63:0]   wdata_next;
    logic [CW-1:0] elem_next;
    logic [CW-1:0] elem_inc;
    logic [31:0]   cyc_next;
    logic          timeout_next;

    assign elem_inc = elem_count + CW'(1);

    // Gating with reset keeps the handshake closed and the core frozen during reset.
    assign in_ready  = !reset && (state == LOAD);
    assign cpu_reset = reset || (state != RUN);
    assign load_done = !reset && ((state == RUN) || (state == DONE));

    always_comb begin
        state_next   = state;
        we_next      = 1'b0;
        addr_next    = mem_addr;
        wdata_next   = mem_wdata;
        elem_next    = elem_count;
        cyc_next     = cycle_count;
        timeout_next = timeout;
        case (state)
            LOAD: begin
                if (in_valid) begin
                    we_next    = 1'b1;
                    addr_next  = BASE_ADDR + (64'(elem_count) << 3);
                    wdata_next = in_data;
                    elem_next  = elem_inc;
                    if (in_last || (elem_inc == CW'(N_ELEM))) begin
                        state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                cyc_next   = 32'd0;
                state_next = RUN;
            end
            RUN: begin
                // Halt wins over the limit: the count is left untouched on a halting edge.
                if (cpu_halt) begin
                    state_next = DONE;
                end else begin
                    cyc_next = cycle_count + 32'd1;
                    if (cyc_next == MAX_CYCLES) begin
                        state_next   = DONE;
                        timeout_next = 1'b1;
                    end
                end
            end
            DONE: begin
                if (restart) begin
                    state_next   = LOAD;
                    elem_next    = '0;
                    cyc_next     = 32'd0;
                    timeout_next = 1'b0;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= LOAD;
            mem_we      <= 1'b0;
            mem_addr    <= 64'd0;
            mem_wdata   <= 64'd0;
            elem_count  <= '0;
            cycle_count <= 32'd0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_next;
            mem_we      <= we_next;
            mem_addr    <= addr_next;
            mem_wdata   <= wdata_next;
            elem_count  <= elem_next;
            cycle_count <= cyc_next;
            timeout     <= timeout_next;
        end
    end

endmodule

// File: tb/tb_sort_array_loader.sv
// Directed bench for sort_array_loader: a table of per-cycle vectors for loading and reset,
// plus hand sequences for halt, restart and timeout (second instance with a short cycle limit).
module tb_sort_array_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_last;
    logic        cpu_halt;
    logic        restart;

    logic        in_ready, mem_we, cpu_reset, load_done, timeout;
    logic [63:0] mem_addr, mem_wdata;
    logic [3:0]  elem_count;
    logic [31:0] cycle_count;

    logic        to_in_ready, to_mem_we, to_cpu_reset, to_load_done, to_timeout;
    logic [63:0] to_mem_addr, to_mem_wdata;
    logic [3:0]  to_elem_count;
    logic [31:0] to_cycle_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sort_array_loader dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .cpu_halt(cpu_halt), .restart(restart),
        .elem_count(elem_count), .cycle_count(cycle_count), .load_done(load_done),
        .timeout(timeout)
    );

    sort_array_loader #(.MAX_CYCLES(32'd16)) dut_to (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(to_in_ready), .mem_we(to_mem_we), .mem_addr(to_mem_addr),
        .mem_wdata(to_mem_wdata), .cpu_reset(to_cpu_reset), .cpu_halt(cpu_halt),
        .restart(restart), .elem_count(to_elem_count), .cycle_count(to_cycle_count),
        .load_done(to_load_done), .timeout(to_timeout)
    );

    typedef struct {
        logic        rst;
        logic        valid;
        logic [63:0] data;
        logic        last;
        logic        exp_we;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [3:0]  exp_cnt;
        logic [31:0] exp_cyc;
        logic        exp_ready;
        logic        exp_cpu_reset;
        logic        exp_ld;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input int rst, input int valid, input longint data, input int last,
                          input int we, input longint addr, input longint wdata, input int cnt,
                          input int cyc, input int ready, input int cpur, input int ld);
        vec_t v;
        v.rst = 1'(rst);
        v.valid = 1'(valid);
        v.data = 64'(data);
        v.last = 1'(last);
        v.exp_we = 1'(we);
        v.exp_addr = 64'(addr);
        v.exp_wdata = 64'(wdata);
        v.exp_cnt = 4'(cnt);
        v.exp_cyc = 32'(cyc);
        v.exp_ready = 1'(ready);
        v.exp_cpu_reset = 1'(cpur);
        v.exp_ld = 1'(ld);
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, let the rising edge pass, and return 1 time unit after it.
    task automatic applyStimulus(input logic rst, input logic valid, input logic [63:0] data,
                                 input logic last, input logic halt, input logic rs);
        reset    = rst;
        in_valid = valid;
        in_data  = data;
        in_last  = last;
        cpu_halt = halt;
        restart  = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic loadOne(input logic [63:0] data);
        applyStimulus(1'b0, 1'b1, data, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        cpu_halt = 1'b0; restart = 1'b0;
        #3;

        // Reset, full 8-element load, flush, release
        addVec(1, 0, 0, 0,   0, 0, 0, 0, 0,   0, 1, 0);
        for (int i = 0; i < 8; i++)
            addVec(0, 1, 8 - i, 0,   1, 8 * i, 8 - i, i + 1, 0,   int'(i < 7), 1, 0);
        addVec(0, 0, 0, 0,   0, 0, 0, 8, 0,   0, 0, 1);
        // Reset mid-RUN
        addVec(1, 0, 0, 0,   0, 0, 0, 0, 0,   0, 1, 0);
        // Short load with gaps; inputs ignored from FLUSH on
        addVec(0, 1, 5, 0,   1, 0, 5, 1, 0,   1, 1, 0);
        addVec(0, 0, 0, 0,   0, 0, 0, 1, 0,   1, 1, 0);
        addVec(0, 1, 9, 0,   1, 8, 9, 2, 0,   1, 1, 0);
        addVec(0, 0, 0, 0,   0, 0, 0, 2, 0,   1, 1, 0);
        addVec(0, 1, 2, 1,   1, 16, 2, 3, 0,  0, 1, 0);
        addVec(0, 1, 99, 0,  0, 0, 0, 3, 0,   0, 0, 1);
        addVec(0, 1, 77, 1,  0, 0, 0, 3, 1,   0, 0, 1);
        // Reset mid-RUN, then reset after 4 transfers, then a fresh transfer
        addVec(1, 0, 0, 0,   0, 0, 0, 0, 0,   0, 1, 0);
        for (int i = 0; i < 4; i++)
            addVec(0, 1, 11 + i, 0,   1, 8 * i, 11 + i, i + 1, 0,   1, 1, 0);
        addVec(1, 1, 55, 0,  0, 0, 0, 0, 0,   0, 1, 0);
        addVec(0, 1, 42, 0,  1, 0, 42, 1, 0,  1, 1, 0);

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            applyStimulus(v.rst, v.valid, v.data, v.last, 1'b0, 1'b0);
            checkOutput($sformatf("vec%0d mem_we", i), 64'(mem_we), 64'(v.exp_we));
            if (v.exp_we || v.rst) begin
                checkOutput($sformatf("vec%0d mem_addr", i), mem_addr, v.exp_addr);
                checkOutput($sformatf("vec%0d mem_wdata", i), mem_wdata, v.exp_wdata);
            end
            checkOutput($sformatf("vec%0d elem_count", i), 64'(elem_count), 64'(v.exp_cnt));
            checkOutput($sformatf("vec%0d cycle_count", i), 64'(cycle_count), 64'(v.exp_cyc));
            checkOutput($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(v.exp_ready));
            checkOutput($sformatf("vec%0d cpu_reset", i), 64'(cpu_reset), 64'(v.exp_cpu_reset));
            checkOutput($sformatf("vec%0d load_done", i), 64'(load_done), 64'(v.exp_ld));
        end

        // Halt after 40 run edges, with a restart pulse in RUN that must be ignored
        applyStimulus(1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        loadOne(64'd7);
        checkOutput("halt run start cycle_count", 64'(cycle_count), 64'd0);
        checkOutput("halt run start cpu_reset", 64'(cpu_reset), 64'd0);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'(i == 20));
            if (i == 20) begin
                checkOutput("restart in RUN load_done", 64'(load_done), 64'd1);
                checkOutput("restart in RUN cpu_reset", 64'(cpu_reset), 64'd0);
                checkOutput("restart in RUN cycle_count", 64'(cycle_count), 64'd21);
            end
        end
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("halt cycle_count", 64'(cycle_count), 64'd40);
        checkOutput("halt timeout", 64'(timeout), 64'd0);
        checkOutput("halt cpu_reset", 64'(cpu_reset), 64'd1);
        checkOutput("halt load_done", 64'(load_done), 64'd1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("done hold cycle_count %0d", i), 64'(cycle_count), 64'd40);
        end

        // Restart from DONE, then a 2-element load from BASE_ADDR
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("restart elem_count", 64'(elem_count), 64'd0);
        checkOutput("restart cycle_count", 64'(cycle_count), 64'd0);
        checkOutput("restart timeout", 64'(timeout), 64'd0);
        checkOutput("restart in_ready", 64'(in_ready), 64'd1);
        checkOutput("restart load_done", 64'(load_done), 64'd0);
        applyStimulus(1'b0, 1'b1, 64'd21, 1'b0, 1'b0, 1'b0);
        checkOutput("reload0 mem_addr", mem_addr, 64'd0);
        checkOutput("reload0 mem_wdata", mem_wdata, 64'd21);
        applyStimulus(1'b0, 1'b1, 64'd22, 1'b0, 1'b0, 1'b0);
        checkOutput("reload1 mem_addr", mem_addr, 64'd8);
        checkOutput("reload1 elem_count", 64'(elem_count), 64'd2);

        // Timeout at 16 run edges on the short-limit instance
        applyStimulus(1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        loadOne(64'd3);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
            if (i == 14) begin
                checkOutput("pre-timeout cycle_count", 64'(to_cycle_count), 64'd15);
                checkOutput("pre-timeout cpu_reset", 64'(to_cpu_reset), 64'd0);
            end
        end
        checkOutput("timeout cycle_count", 64'(to_cycle_count), 64'd16);
        checkOutput("timeout flag", 64'(to_timeout), 64'd1);
        checkOutput("timeout cpu_reset", 64'(to_cpu_reset), 64'd1);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("timeout hold cycle_count", 64'(to_cycle_count), 64'd16);

        // Halt on the same edge the limit would be reached
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("to restart timeout", 64'(to_timeout), 64'd0);
        loadOne(64'd4);
        for (int i = 0; i < 15; i++)
            applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("halt at limit timeout", 64'(to_timeout), 64'd0);
        checkOutput("halt at limit cycle_count", 64'(to_cycle_count), 64'd15);
        checkOutput("halt at limit cpu_reset", 64'(to_cpu_reset), 64'd1);
        checkOutput("halt at limit load_done", 64'(to_load_done), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sort_array_loader.md
# sort_array_loader

Front-end loader sitting directly upstream of the single-cycle RISC-V core and its data memory. It accepts a stream of 64-bit array elements over a valid/ready handshake and writes them into consecutive doubleword addresses of data memory. While it loads, it holds the core in reset. It then releases the core, counts run cycles until the core signals halt or a timeout expires, and parks in a done state until restarted.

## Interface
Parameters:
- N_ELEM, 8, maximum elements per load; a load auto-terminates at this count
- BASE_ADDR, 64'd0, byte address of element 0
- MAX_CYCLES, 32'd10000, run-cycle timeout limit

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high; sampled on clk rising edge
- in_valid  input  1  element offered
- in_data  input  64  element value
- in_last  input  1  qualifies in_data as the final element of a short load
- in_ready  output  1  loader can accept; transfer = in_valid && in_ready at a rising edge
- mem_we  output  1  data-memory write strobe (registered)
- mem_addr  output  64  data-memory byte address (registered)
- mem_wdata  output  64  data-memory write data (registered)
- cpu_reset  output  1  drives the core's reset input
- cpu_halt  input  1  core finished (halt detect from the core)
- restart  input  1  return to LOAD from DONE
- elem_count  output  4  elements accepted in this load, width clog2(N_ELEM+1)
- cycle_count  output  32  run cycles counted
- load_done  output  1  high in RUN and DONE
- timeout  output  1  DONE was reached by timeout, not by halt

## Operation
- States: LOAD, FLUSH, RUN, DONE. Reset enters LOAD.
- LOAD
  - in_ready = 1, cpu_reset = 1.
  - Each transfer registers mem_we=1, mem_addr=BASE_ADDR+8*elem_count (old value), mem_wdata=in_data, and increments elem_count.
  - If the transfer carries in_last=1, or elem_count becomes N_ELEM, the next state is FLUSH.
  - With no transfer, mem_we registers 0.
- FLUSH
  - in_ready = 0, cpu_reset = 1.
  - The final write is on the bus this cycle.
  - mem_we registers 0.
  - Next state is RUN, with cycle_count cleared to 0.
- RUN
  - cpu_reset = 0, in_ready = 0, load_done = 1.
  - Rising edge with cpu_halt=1: next state DONE; cycle_count holds. Halt has priority over timeout.
  - Rising edge with cpu_halt=0: cycle_count increments. If the new value equals MAX_CYCLES, the next state is DONE and timeout registers 1.
- DONE
  - cpu_reset = 1, which freezes the core. Data memory is not affected by cpu_reset.
  - cycle_count, elem_count, and timeout hold.
  - restart=1: next state LOAD; elem_count, cycle_count, and timeout clear.
- restart is ignored outside DONE. in_valid, in_data, and in_last are ignored outside LOAD.
- mem_addr arithmetic is 64-bit unsigned. elem_count never exceeds N_ELEM.

## Timing
- Values while reset is asserted and on the first cycle after it:
  - state LOAD
  - mem_we=0, mem_addr=0, mem_wdata=0
  - elem_count=0, cycle_count=0
  - load_done=0, timeout=0
  - cpu_reset=1
- in_ready is 0 while reset is high and 1 from the first cycle after it.
- in_ready is a combinational decode of state only; it does not depend on in_valid.
- Write latency: a transfer at edge E puts mem_we high from E to E+1. Back-to-back transfers give a continuous mem_we with incrementing addresses.
- Release latency: for a final transfer at edge E, state is FLUSH during E..E+1, and cpu_reset falls after edge E+1. The core therefore never runs while a loader write is pending.
- cycle_count equals the number of RUN edges that saw cpu_halt=0. Halt asserted on the first RUN cycle gives cycle_count=0.
- Reset asserted mid-LOAD, mid-RUN, or in DONE: all state returns to reset values at that edge, including cpu_reset=1. Memory words already written remain.

## Test plan
- Full load: 8 back-to-back transfers of 64'd8..64'd1 starting at BASE_ADDR=0.
  - mem_we is high for 8 consecutive cycles, addresses 0,8,...,56.
  - One FLUSH cycle follows, then cpu_reset=0 and load_done=1.
  - elem_count=8.
- Short load with gaps: 3 transfers (5, 9, 2) with in_valid low between them, the third with in_last=1.
  - Writes go to addresses 0, 8, 16 only.
  - elem_count=3, then RUN.
  - in_ready is 0 from FLUSH onward.
- Halt: in RUN, hold cpu_halt low for 40 edges, then raise it.
  - State is DONE, cycle_count=40, timeout=0, cpu_reset=1.
  - cycle_count stays stable for 10 further cycles.
- Timeout: MAX_CYCLES=16, cpu_halt held low.
  - DONE after 16 RUN edges with cycle_count=16 and timeout=1.
  - Halt and limit reached on the same edge: timeout=0.
- Restart: pulse restart in DONE, then load 2 elements.
  - Counts clear and the state is LOAD.
  - Addresses restart at BASE_ADDR. restart pulsed during RUN has no effect.
- Reset mid-operation: reset asserted after 4 transfers.
  - The next cycle shows elem_count=0, mem_we=0, cpu_reset=1.
  - The next transfer writes address BASE_ADDR.
